// File: rtl/cache_req_arbiter.sv
// Serialises instruction/data requests from NCPU cores onto one single-port memory.
// Optional build macro CACHE_ARB_RR_EN selects round-robin core arbitration (default: fixed priority).
module cache_req_arbiter #(
    parameter int NCPU   = 2,
    parameter int WORD_W = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NCPU-1:0]               halt,
    input  logic [NCPU-1:0]               iREN,
    input  logic [NCPU-1:0][WORD_W-1:0]   iaddr,
    input  logic [NCPU-1:0]               dREN,
    input  logic [NCPU-1:0]               dWEN,
    input  logic [NCPU-1:0][WORD_W-1:0]   daddr,
    input  logic [NCPU-1:0][WORD_W-1:0]   dstore,
    output logic [NCPU-1:0]               ihit,
    output logic [NCPU-1:0]               dhit,
    output logic [NCPU-1:0][WORD_W-1:0]   iload,
    output logic [NCPU-1:0][WORD_W-1:0]   dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [WORD_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore,
    input  logic [WORD_W-1:0]             ramload,
    input  logic                          ramwait,
    output logic [1:0]                    o_dbg_state
);
    localparam int GW = (NCPU > 1) ? $clog2(NCPU) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HIT    = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [GW-1:0]                 r_grant;
    logic [GW-1:0]                 w_sel;
    logic                          w_found;
    logic                          r_kind_d;
    logic                          r_write;
    logic [NCPU-1:0]               w_elig;
    logic [NCPU-1:0][WORD_W-1:0]   r_iload;
    logic [NCPU-1:0][WORD_W-1:0]   r_dload;

    assign w_elig = ~halt & (iREN | dREN | dWEN);

`ifdef CACHE_ARB_RR_EN
    logic [GW-1:0] r_ptr;

    always_comb begin : p_sel_rr
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NCPU; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCPU) idx = idx - NCPU;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sel   = GW'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ptr <= '0;
        end else if (r_state == HIT) begin
            r_ptr <= (int'(r_grant) + 1 >= NCPU) ? '0 : r_grant + 1'b1;
        end
    end
`else
    always_comb begin : p_sel_fixed
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NCPU - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_found = 1'b1;
                w_sel   = GW'(k);
            end
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = ACCESS;
            ACCESS:  if (!ramwait) w_next = HIT;
            HIT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The read/write choice is frozen at grant so a dropped request never aborts the access.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = '0;
        dhit     = '0;
        if (r_state == ACCESS) begin
            ramWEN  = r_write;
            ramREN  = ~r_write;
            ramaddr = r_kind_d ? daddr[r_grant] : iaddr[r_grant];
            if (r_write) ramstore = dstore[r_grant];
        end
        if (r_state == HIT) begin
            if (r_kind_d) dhit[r_grant] = 1'b1;
            else          ihit[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_kind_d <= 1'b0;
            r_write  <= 1'b0;
            r_iload  <= '0;
            r_dload  <= '0;
        end else begin
            r_state <= w_next;
            // Data beats instruction within a core; dWEN with dREN is a write.
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_sel;
                r_kind_d <= dREN[w_sel] | dWEN[w_sel];
                r_write  <= dWEN[w_sel];
            end
            if (r_state == ACCESS && !ramwait && !r_write) begin
                if (r_kind_d) r_dload[r_grant] <= ramload;
                else          r_iload[r_grant] <= ramload;
            end
        end
    end

    assign iload       = r_iload;
    assign dload       = r_dload;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: directed scenarios plus a randomized run
// against a transaction-timeline reference model with a simple backing memory.
`timescale 1ns/1ps
module tb_cache_req_arbiter;
    localparam int NCPU = 2;
    localparam int W    = 32;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic [NCPU-1:0]         halt, iREN, dREN, dWEN;
    logic [NCPU-1:0][W-1:0]  iaddr, daddr, dstore;
    logic [NCPU-1:0]         ihit, dhit;
    logic [NCPU-1:0][W-1:0]  iload, dload;
    logic                    ramREN, ramWEN, ramwait;
    logic [W-1:0]            ramaddr, ramstore, ramload;
    logic [1:0]              dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [W-1:0] ram_mem[logic [W-1:0]];
    logic [W-1:0] ref_mem[logic [W-1:0]];

    cache_req_arbiter #(.NCPU(NCPU), .WORD_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt), .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] dflt(input logic [W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [W-1:0] ram_lookup(input logic [W-1:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic logic [W-1:0] ref_lookup(input logic [W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic do_reset();
        nRST = 1'b0; halt = '0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramwait = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic wait_any_hit(input int max_cyc, output logic [2*NCPU-1:0] hv);
        bit done;
        done = 1'b0;
        hv   = '0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge CLK);
            if ((ihit | dhit) != '0) begin
                hv   = {dhit, ihit};
                done = 1'b1;
            end
        end
    endtask

    // driver / check tasks
    task automatic test_reset();
        do_reset();
        checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== '0) begin
            failures++;
            $display("FAIL reset_strobes got ihit=%b dhit=%b ramREN=%b ramWEN=%b, want all 0", ihit, dhit, ramREN, ramWEN);
        end
        checks++;
        if (ramaddr !== '0 || ramstore !== '0) begin
            failures++;
            $display("FAIL reset_ram_bus got addr=%h store=%h, want 0", ramaddr, ramstore);
        end
        checks++;
        if (iload !== '0 || dload !== '0) begin
            failures++;
            $display("FAIL reset_loads got iload=%h dload=%h, want 0", iload, dload);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got %0d want 0 (IDLE)", dbg_state);
        end
    endtask

    task automatic test_ifetch();
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramload = 32'hDEADBEEF; ramwait = 1'b0;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== '0) begin
            failures++;
            $display("FAIL ifetch_access got REN=%b WEN=%b addr=%h ihit=%b, want 1 0 00000040 00", ramREN, ramWEN, ramaddr, ihit);
        end
        @(negedge CLK);
        checks++;
        if (ihit !== 2'b01 || dhit !== 2'b00) begin
            failures++;
            $display("FAIL ifetch_hit got ihit=%b dhit=%b, want 01 00", ihit, dhit);
        end
        checks++;
        if (iload[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ifetch_iload got %h want deadbeef", iload[0]);
        end
        iREN[0] = 1'b0;
        @(negedge CLK);
        checks++;
        if (ihit !== '0 || ramREN !== 1'b0 || iload[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ifetch_pulse got ihit=%b ramREN=%b iload=%h, want 00 0 deadbeef", ihit, ramREN, iload[0]);
        end
    endtask

    task automatic test_write_wait();
        dWEN[0] = 1'b1; daddr[0] = 32'h80; dstore[0] = 32'h1234;
        ramwait = 1'b1; ramload = 32'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h80 || dhit !== '0) begin
                failures++;
                $display("FAIL write_access[%0d] got WEN=%b REN=%b store=%h addr=%h dhit=%b, want 1 0 00001234 00000080 00",
                         i, ramWEN, ramREN, ramstore, ramaddr, dhit);
            end
            if (i == 3) ramwait = 1'b0;
        end
        @(negedge CLK);
        checks++;
        if (dhit !== 2'b01 || ihit !== '0 || ramWEN !== 1'b0) begin
            failures++;
            $display("FAIL write_hit got dhit=%b ihit=%b WEN=%b, want 01 00 0", dhit, ihit, ramWEN);
        end
        checks++;
        if (dload[0] !== '0) begin
            failures++;
            $display("FAIL write_dload got %h want 00000000", dload[0]);
        end
        dWEN[0] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_d_over_i();
        logic [2*NCPU-1:0] hv;
        dREN[1] = 1'b1; iREN[1] = 1'b1; daddr[1] = 32'h100; iaddr[1] = 32'h200;
        ramload = 32'h11112222; ramwait = 1'b0;
        wait_any_hit(10, hv);
        checks++;
        if (hv !== 4'b1000 || dload[1] !== 32'h11112222) begin
            failures++;
            $display("FAIL d_over_i_first got hits=%b dload1=%h, want 1000 11112222", hv, dload[1]);
        end
        dREN[1] = 1'b0; ramload = 32'h33334444;
        wait_any_hit(10, hv);
        checks++;
        if (hv !== 4'b0010 || iload[1] !== 32'h33334444) begin
            failures++;
            $display("FAIL d_over_i_second got hits=%b iload1=%h, want 0010 33334444", hv, iload[1]);
        end
        iREN[1] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_arbitration();
        logic [2*NCPU-1:0] hv, exp_hv;
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h14; ramload = 32'hCAFE0000;
        for (int i = 0; i < 4; i++) begin
            wait_any_hit(10, hv);
            exp_hv = (RR && (i % 2 == 1)) ? 4'b0010 : 4'b0001;
            checks++;
            if (hv !== exp_hv) begin
                failures++;
                $display("FAIL arbitration[%0d] got hits=%b want %b", i, hv, exp_hv);
            end
        end
        iREN = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_halt();
        logic [2*NCPU-1:0] hv;
        halt = 2'b01; iREN = 2'b11; iaddr[0] = 32'h20; iaddr[1] = 32'h24; ramwait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_any_hit(10, hv);
            checks++;
            if (hv !== 4'b0010) begin
                failures++;
                $display("FAIL halt_mask[%0d] got hits=%b want 0010", i, hv);
            end
        end
        iREN = '0; halt = '0;
        repeat (2) @(negedge CLK);
        iREN[0] = 1'b1; ramwait = 1'b1; ramload = 32'h0BADF00D;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin
            failures++;
            $display("FAIL halt_access got REN=%b addr=%h want 1 00000020", ramREN, ramaddr);
        end
        halt[0] = 1'b1;
        @(negedge CLK);
        ramwait = 1'b0;
        wait_any_hit(5, hv);
        checks++;
        if (hv !== 4'b0001 || iload[0] !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL halt_inflight got hits=%b iload0=%h want 0001 0badf00d", hv, iload[0]);
        end
        iREN = '0; halt = '0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int bad;
        dREN[1] = 1'b1; daddr[1] = 32'h300; ramwait = 1'b1;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
            failures++;
            $display("FAIL rstmid_access got REN=%b addr=%h want 1 00000300", ramREN, ramaddr);
        end
        nRST = 1'b0; dREN = '0;
        @(negedge CLK);
        checks++;
        if ({ihit, dhit, ramREN, ramWEN} !== '0 || ramaddr !== '0 || ramstore !== '0 ||
            iload !== '0 || dload !== '0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got ihit=%b dhit=%b REN=%b WEN=%b addr=%h state=%0d, want all 0",
                     ihit, dhit, ramREN, ramWEN, ramaddr, dbg_state);
        end
        nRST = 1'b1; ramwait = 1'b0; bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if ((ihit | dhit) != '0 || ramREN || ramWEN) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_no_hit got %0d active cycles after reset want 0", bad);
        end
    endtask

    task automatic test_random();
        int m_phase, m_g, m_ptr, c, n_code;
        bit m_d, m_w, found;
        logic [NCPU-1:0] elig;
        logic [NCPU-1:0] exp_ih, exp_dh;
        logic [NCPU-1:0][W-1:0] e_iload, e_dload;
        logic [W-1:0] exp_addr, exp_store;
        logic [7:0] code, obs;
        do_reset();
        ram_mem.delete(); ref_mem.delete(); exp_q.delete();
        m_phase = 0; m_g = 0; m_ptr = 0; m_d = 0; m_w = 0;
        e_iload = '0; e_dload = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge CLK);
            // advance the transaction timeline by the edge just taken
            case (m_phase)
                0: begin
                    elig = ~halt & (iREN | dREN | dWEN);
                    found = 1'b0;
                    for (int k = 0; k < NCPU; k++) begin
                        c = RR ? (m_ptr + k) % NCPU : k;
                        if (!found && elig[c]) begin
                            found = 1'b1; m_g = c;
                        end
                    end
                    if (found) begin
                        m_d = dREN[m_g] | dWEN[m_g];
                        m_w = dWEN[m_g];
                        m_phase = 1;
                        exp_q.push_back(8'(m_g) + (m_d ? 8'd16 : 8'd0));
                    end
                end
                1: if (!ramwait) begin
                    m_phase = 2;
                    if (m_w) ref_mem[daddr[m_g]] = dstore[m_g];
                    else if (m_d) e_dload[m_g] = ref_lookup(daddr[m_g]);
                    else e_iload[m_g] = ref_lookup(iaddr[m_g]);
                end
                default: begin
                    m_phase = 0;
                    m_ptr = (m_g + 1) % NCPU;
                end
            endcase
            exp_addr = '0; exp_store = '0; exp_ih = '0; exp_dh = '0;
            if (m_phase == 1) begin
                exp_addr  = m_d ? daddr[m_g] : iaddr[m_g];
                exp_store = m_w ? dstore[m_g] : '0;
            end
            if (m_phase == 2) begin
                if (m_d) exp_dh[m_g] = 1'b1;
                else     exp_ih[m_g] = 1'b1;
            end
            checks++;
            if (ramREN !== (m_phase == 1 && !m_w) || ramWEN !== (m_phase == 1 && m_w) ||
                ramaddr !== exp_addr || ramstore !== exp_store) begin
                failures++;
                $display("FAIL rand_ram cyc=%0d got REN=%b WEN=%b addr=%h store=%h want REN=%b WEN=%b addr=%h store=%h",
                         cyc, ramREN, ramWEN, ramaddr, ramstore, (m_phase == 1 && !m_w), (m_phase == 1 && m_w), exp_addr, exp_store);
            end
            checks++;
            if (ihit !== exp_ih || dhit !== exp_dh) begin
                failures++;
                $display("FAIL rand_hit cyc=%0d got ihit=%b dhit=%b want ihit=%b dhit=%b", cyc, ihit, dhit, exp_ih, exp_dh);
            end
            checks++;
            if (iload !== e_iload || dload !== e_dload) begin
                failures++;
                $display("FAIL rand_load cyc=%0d got iload=%h dload=%h want iload=%h dload=%h", cyc, iload, dload, e_iload, e_dload);
            end
            n_code = $countones({ihit, dhit});
            if (n_code != 0) begin
                obs = '0;
                for (int k = 0; k < NCPU; k++) begin
                    if (ihit[k]) obs = 8'(k);
                    if (dhit[k]) obs = 8'(k) + 8'd16;
                end
                code = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
                checks++;
                if (n_code != 1 || obs !== code) begin
                    failures++;
                    $display("FAIL rand_order cyc=%0d got code=%h (%0d hits) want code=%h", cyc, obs, n_code, code);
                end
            end
            // requester behaviour: drop on completion, start new work when idle
            if (m_phase == 2) begin
                if (m_d) begin dREN[m_g] = 1'b0; dWEN[m_g] = 1'b0; end
                else iREN[m_g] = 1'b0;
            end
            for (int k = 0; k < NCPU; k++) begin
                if (!iREN[k] && !dREN[k] && !dWEN[k] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 4))
                        0: iREN[k] = 1'b1;
                        1: dREN[k] = 1'b1;
                        2: dWEN[k] = 1'b1;
                        3: begin iREN[k] = 1'b1; dREN[k] = 1'b1; end
                        default: begin dREN[k] = 1'b1; dWEN[k] = 1'b1; end
                    endcase
                    iaddr[k]  = W'($urandom_range(0, 7)) << 2;
                    daddr[k]  = W'($urandom_range(0, 7)) << 2;
                    dstore[k] = $urandom;
                end
            end
            if ($urandom_range(0, 7) == 0) halt[$urandom_range(0, NCPU - 1)] ^= 1'b1;
            #1;
            ramwait = ($urandom_range(0, 3) == 0);
            ramload = ramREN ? ram_lookup(ramaddr) : W'($urandom);
            if (ramWEN && !ramwait) ram_mem[ramaddr] = ramstore;
        end
        iREN = '0; dREN = '0; dWEN = '0; halt = '0;
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write_wait();
        test_d_over_i();
        test_arbitration();
        test_halt();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
